// File: rtl/ureg_bank.sv
// ureg_bank: W-bit universal register (load/shift/rotate/inc/dec) with registered carry and zero flags.
// Optional undo of the last modifying op when compiled with UREG_UNDO_EN.
module ureg_bank #(
  parameter int unsigned W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [2:0]   op,
  input  logic [W-1:0] sw,
  input  logic         sin,
`ifdef UREG_UNDO_EN
  input  logic         undo,
`endif
  output logic [W-1:0] qout,
  output logic         cout,
  output logic         zero
);
  logic [W-1:0] r_q;
  logic         r_c;
  logic         r_z;
  logic [W-1:0] w_nq;
  logic         w_nc;
  always_comb begin
    w_nq = r_q;
    w_nc = r_c;
    case (op)
      3'b001: begin w_nq = sw;                    w_nc = 1'b0;     end
      3'b010: begin w_nq = {r_q[W-2:0], sin};     w_nc = r_q[W-1]; end
      3'b011: begin w_nq = {sin, r_q[W-1:1]};     w_nc = r_q[0];   end
      3'b100: begin w_nq = {r_q[W-2:0], r_q[W-1]}; w_nc = r_q[W-1]; end
      3'b101: begin w_nq = {r_q[0], r_q[W-1:1]};  w_nc = r_q[0];   end
      3'b110: {w_nc, w_nq} = {1'b0, r_q} + {{W{1'b0}}, 1'b1};
      3'b111: {w_nc, w_nq} = {1'b0, r_q} - {{W{1'b0}}, 1'b1};
      default: ;
    endcase
  end
`ifdef UREG_UNDO_EN
  logic [W-1:0] r_prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= RST_VAL;
      r_c    <= 1'b0;
      r_z    <= (RST_VAL == '0);
      r_prev <= RST_VAL;
    end else if (undo) begin
      r_q <= r_prev;
      r_c <= 1'b0;
      r_z <= (r_prev == '0);
    end else if (en) begin
      r_q <= w_nq;
      r_c <= w_nc;
      r_z <= (w_nq == '0);
      if (op != 3'b000) r_prev <= r_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
      r_c <= 1'b0;
      r_z <= (RST_VAL == '0);
    end else if (en) begin
      r_q <= w_nq;
      r_c <= w_nc;
      r_z <= (w_nq == '0);
    end
  end
`endif
  assign qout = r_q;
  assign cout = r_c;
  assign zero = r_z;
endmodule

// File: tb/tb_ureg_bank.sv
// tb_ureg_bank: directed-vector bench for ureg_bank (W=8 and W=12/RST_VAL=ABC instances).
module tb_ureg_bank;
  logic        clk = 1'b0;
  logic        rst, en, sin;
  logic [2:0]  op;
  logic [7:0]  sw;
  logic [11:0] sw12;
  logic [7:0]  q8;
  logic [11:0] q12;
  logic        c8, z8, c12, z12;
`ifdef UREG_UNDO_EN
  logic        undo;
`endif
  int n_cmp = 0;
  int n_err = 0;
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROL = 3'd4, ROR = 3'd5, INC = 3'd6, DEC = 3'd7;
  always #5 clk = ~clk;
  assign sw12 = {4'h0, sw};
  ureg_bank #(.W(8), .RST_VAL(8'h00)) u8 (
    .clk(clk), .rst(rst), .en(en), .op(op), .sw(sw), .sin(sin),
`ifdef UREG_UNDO_EN
    .undo(undo),
`endif
    .qout(q8), .cout(c8), .zero(z8));
  ureg_bank #(.W(12), .RST_VAL(12'hABC)) u12 (
    .clk(clk), .rst(rst), .en(en), .op(op), .sw(sw12), .sin(sin),
`ifdef UREG_UNDO_EN
    .undo(undo),
`endif
    .qout(q12), .cout(c12), .zero(z12));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk8(input string tag, input logic [7:0] q, input logic c, input logic z);
    chk({tag, ".q"}, {24'h0, q8}, {24'h0, q});
    chk({tag, ".c"}, {31'h0, c8}, {31'h0, c});
    chk({tag, ".z"}, {31'h0, z8}, {31'h0, z});
  endtask
  task automatic do_op(input logic [2:0] o, input logic [7:0] d, input logic s);
    en = 1'b1; op = o; sw = d; sin = s;
    step();
  endtask
  initial begin
    rst = 1'b1; en = 1'b1; op = LOAD; sw = 8'hF0; sin = 1'b0;
`ifdef UREG_UNDO_EN
    undo = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      chk8("rst_hold", 8'h00, 1'b0, 1'b1);
      chk("rst12.q", {20'h0, q12}, 32'hABC);
      chk("rst12.z", {31'h0, z12}, 32'h0);
    end
    rst = 1'b0;
    step();
    chk8("rel_load_f0", 8'hF0, 1'b0, 1'b0);
    do_op(LOAD, 8'h81, 1'b0); chk8("load_81", 8'h81, 1'b0, 1'b0);
    do_op(SHL, 8'hAA, 1'b0);  chk8("shl", 8'h02, 1'b1, 1'b0);
    do_op(SHR, 8'hAA, 1'b1);  chk8("shr", 8'h81, 1'b0, 1'b0);
    do_op(LOAD, 8'h81, 1'b0); chk8("load_81b", 8'h81, 1'b0, 1'b0);
    do_op(ROL, 8'h00, 1'b0);  chk8("rol", 8'h03, 1'b1, 1'b0);
    do_op(ROR, 8'h00, 1'b0);  chk8("ror", 8'h81, 1'b1, 1'b0);
    en = 1'b0; op = INC;
    for (int i = 0; i < 5; i++) begin
      step();
      chk8("en0_inc", 8'h81, 1'b1, 1'b0);
    end
    do_op(HOLD, 8'h55, 1'b1); chk8("hold", 8'h81, 1'b1, 1'b0);
    do_op(LOAD, 8'hFE, 1'b0); chk8("load_fe", 8'hFE, 1'b0, 1'b0);
    do_op(INC, 8'h00, 1'b0);  chk8("inc_ff", 8'hFF, 1'b0, 1'b0);
    do_op(INC, 8'h00, 1'b0);  chk8("inc_wrap", 8'h00, 1'b1, 1'b1);
    do_op(DEC, 8'h00, 1'b0);  chk8("dec_wrap", 8'hFF, 1'b1, 1'b0);
    do_op(DEC, 8'h00, 1'b0);  chk8("dec_fe", 8'hFE, 1'b0, 1'b0);
    rst = 1'b1;
    do_op(LOAD, 8'h55, 1'b0); chk8("rst_vs_load", 8'h00, 1'b0, 1'b1);
    chk("rst12_mid.q", {20'h0, q12}, 32'hABC);
    rst = 1'b0;
    do_op(LOAD, 8'h55, 1'b0); chk8("post_rst_load", 8'h55, 1'b0, 1'b0);
    do_op(INC, 8'h00, 1'b0);  chk8("post_rst_inc", 8'h56, 1'b0, 1'b0);
    chk("u12_inc.q", {20'h0, q12}, 32'h056);
`ifdef UREG_UNDO_EN
    do_op(LOAD, 8'h0F, 1'b0); chk8("u_load_0f", 8'h0F, 1'b0, 1'b0);
    do_op(LOAD, 8'hF0, 1'b0); chk8("u_load_f0", 8'hF0, 1'b0, 1'b0);
    en = 1'b0; undo = 1'b1;
    step(); chk8("undo1", 8'h0F, 1'b0, 1'b0);
    step(); chk8("undo2", 8'h0F, 1'b0, 1'b0);
    do_op(INC, 8'h00, 1'b0); chk8("undo_wins", 8'h0F, 1'b0, 1'b0);
    undo = 1'b0;
    do_op(INC, 8'h00, 1'b0); chk8("after_undo_inc", 8'h10, 1'b0, 1'b0);
    undo = 1'b1; en = 1'b0;
    step(); chk8("undo_after_inc", 8'h0F, 1'b0, 1'b0);
    undo = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ureg_bank.md
# ureg_bank

Parametrised universal register: W-bit register with parallel load, one-bit shift/rotate, and increment/decrement, selected per cycle by an opcode. Generalises the team's 8-bit load register (clk/rst/ldp/sw/qout) to any width and a full operation set, with registered status flags. Sits between the switch/input stage and the display/datapath stages. Registered output only; no combinational path from inputs to `qout`.

## Interface
Parameters:
- `W`, 8: register width, W ≥ 2.
- `RST_VAL`, 0: value of `qout` after reset, W bits.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  operation enable; `op` ignored when 0.
- `op`  in  3  opcode (see Operation).
- `sw`  in  W  parallel load data.
- `sin`  in  1  serial input for shifts.
- `undo`  in  1  restore previous value; present only with `UREG_UNDO_EN`.
- `qout`  out  W  register contents.
- `cout`  out  1  registered carry/borrow/shifted-out bit.
- `zero`  out  1  registered flag, 1 iff `qout` == 0.

## Operation
- Priority per edge: `rst` > `undo` (if compiled) > `en`/`op` > hold.
- `rst`=1: `qout`←RST_VAL, `cout`←0, `zero`←(RST_VAL==0); undo register←RST_VAL.
- `en`=0: all state holds.
- `en`=1, `op`:
  - 000 HOLD: no change, `cout` holds.
  - 001 LOAD: `qout`←`sw`, `cout`←0.
  - 010 SHL: `qout`←{q[W-2:0],`sin`}, `cout`←q[W-1].
  - 011 SHR: `qout`←{`sin`,q[W-1:1]}, `cout`←q[0].
  - 100 ROL: `qout`←{q[W-2:0],q[W-1]}, `cout`←q[W-1].
  - 101 ROR: `qout`←{q[0],q[W-1:1]}, `cout`←q[0].
  - 110 INC: `qout`←q+1 mod 2^W, `cout`←1 iff q was all-ones (wraps to 0).
  - 111 DEC: `qout`←q−1 mod 2^W, `cout`←1 iff q was 0 (wraps to all-ones).
- `zero` updated together with `qout`; always equals (`qout`==0) in the same cycle.
- Arithmetic is unsigned, W+1-bit internal sum; no saturation.

## Timing
- Latency 1 cycle: inputs sampled at edge k appear on `qout`/`cout`/`zero` after edge k.
- Back-to-back operations every cycle; no stall, no busy.
- Reset mid-sequence overrides any op in that same cycle; next cycle resumes normally.
- `sw`/`sin` ignored except when the selected op consumes them.
- Output reset values: `qout`=RST_VAL, `cout`=0, `zero`=(RST_VAL==0).

## Configuration
- `UREG_UNDO_EN` defined: adds `undo` port and W-bit `prev` register. Every `en`=1 edge with op≠HOLD and `undo`=0 captures `prev`←current `qout`. `undo`=1 (regardless of `en`): `qout`←`prev`, `cout`←0, `zero` recomputed, `prev` unchanged (repeated undo idempotent).
- Not defined: no `undo` port, no `prev` register; behaviour otherwise identical.

## Test plan
- W=8, RST_VAL=0: hold `rst` 3 cycles, `en`=1 op=LOAD `sw`=F0 → `qout` stays 00, `zero`=1 while `rst`=1; after release, next edge `qout`=F0, `zero`=0.
- LOAD 81, then SHL `sin`=0 → `qout`=02, `cout`=1; then SHR `sin`=1 → `qout`=81, `cout`=0.
- LOAD 81, ROL → 03 `cout`=1; ROR → 81 `cout`=1; `en`=0 with op=INC for 5 cycles → `qout` stays 81.
- LOAD FE, INC → FF `cout`=0; INC → 00 `cout`=1 `zero`=1; DEC → FF `cout`=1 `zero`=0.
- `rst`=1 asserted in same cycle as LOAD 55 → `qout`=00, `cout`=0; W=12 RST_VAL=ABC build: reset → `qout`=ABC.
- With `UREG_UNDO_EN`: LOAD 0F, LOAD F0, `undo`=1 → `qout`=0F; `undo` again → 0F; `undo`=1 with `en`=1 op=INC → `qout`=0F (undo wins).
